// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the multi-domain reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_PWR,
    S_RST,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam int N_STAGE_DEF   = 4;
  localparam int MAX_RETRY_DEF = 3;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int STAGE_W = width_of(N_STAGE_DEF);
  localparam int RETRY_W = width_of(MAX_RETRY_DEF + 1);

endpackage

// File: rtl/reset_sequencer_if.sv
// Per-domain control/status bundle between the sequencer and the board domains.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int N_STAGE = N_STAGE_DEF,
  parameter int STAGE_W = width_of(N_STAGE)
);
  logic [N_STAGE-1:0] ready;
  logic               restart_req;
  logic [N_STAGE-1:0] pwrdwn;
  logic [N_STAGE-1:0] rst;
  logic               done;
  logic               fault;
  logic [STAGE_W-1:0] stage;

  modport master (
    input  ready, restart_req,
    output pwrdwn, rst, done, fault, stage
  );

  modport slave (
    output ready, restart_req,
    input  pwrdwn, rst, done, fault, stage
  );
endinterface

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, cleared asynchronously.
module bit_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// Releases dependent board domains in index order, waiting for each lock,
// with per-stage retry, lock-loss re-sequencing and fault reporting.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGE        = 4,
  parameter int PWR_CYCLES     = 1000000,
  parameter int RST_CYCLES     = 20000,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 32
) (
  input logic               clk,
  input logic               rst_n,
  reset_sequencer_if.master bus
);
  localparam int SW = width_of(N_STAGE);
  localparam int RW = width_of(MAX_RETRY + 1);

  logic [N_STAGE-1:0] rdy_s;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_clr;
  logic [SW-1:0]      stage_q, stage_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [N_STAGE-1:0] pwrdwn_q, pwrdwn_d;
  logic [N_STAGE-1:0] rst_q, rst_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic               loss_hit;
  logic [SW-1:0]      loss_idx;
  logic [N_STAGE-1:0] above_loss, above_stage;
  logic               loss_check;

  for (genvar i = 0; i < N_STAGE; i++) begin : g_sync
    bit_sync2 u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (bus.ready[i]),
      .q    (rdy_s[i])
    );
  end

  // Lowest unlocked domain wins; in S_DONE every domain is watched.
  always_comb begin
    loss_hit    = 1'b0;
    loss_idx    = '0;
    above_loss  = '0;
    above_stage = '0;
    for (int j = N_STAGE - 1; j >= 0; j--) begin
      if (!rdy_s[j] && (state_q == S_DONE || j < int'(stage_q))) begin
        loss_hit = 1'b1;
        loss_idx = SW'(j);
      end
    end
    for (int k = 0; k < N_STAGE; k++) begin
      above_loss[k]  = (k >= int'(loss_idx));
      above_stage[k] = (k >= int'(stage_q));
    end
  end

  assign loss_check = (state_q == S_RST) || (state_q == S_WAIT) || (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    retry_d  = retry_q;
    pwrdwn_d = pwrdwn_q;
    rst_d    = rst_q;
    done_d   = done_q;
    fault_d  = fault_q;
    cnt_clr  = 1'b0;
    if (bus.restart_req) begin
      state_d  = S_PWR;
      stage_d  = '0;
      retry_d  = '0;
      pwrdwn_d = '1;
      rst_d    = '1;
      done_d   = 1'b0;
      fault_d  = 1'b0;
      cnt_clr  = 1'b1;
    end else if (loss_check && loss_hit) begin
      state_d  = S_PWR;
      stage_d  = loss_idx;
      retry_d  = '0;
      pwrdwn_d = pwrdwn_q | above_loss;
      rst_d    = rst_q | above_loss;
      done_d   = 1'b0;
      cnt_clr  = 1'b1;
    end else begin
      case (state_q)
        S_PWR: begin
          if (cnt_q == CNT_W'(PWR_CYCLES - 1)) begin
            pwrdwn_d[stage_q] = 1'b0;
            state_d           = S_RST;
            cnt_clr           = 1'b1;
          end
        end
        S_RST: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            rst_d[stage_q] = 1'b0;
            state_d        = S_WAIT;
            cnt_clr        = 1'b1;
          end
        end
        S_WAIT: begin
          // A timeout outranks a lock arriving in the same cycle.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_clr = 1'b1;
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d           = retry_q + 1'b1;
              pwrdwn_d[stage_q] = 1'b1;
              rst_d[stage_q]    = 1'b1;
              state_d           = S_PWR;
            end else begin
              pwrdwn_d = pwrdwn_q | above_stage;
              rst_d    = rst_q | above_stage;
              fault_d  = 1'b1;
              state_d  = S_FAULT;
            end
          end else if (rdy_s[stage_q]) begin
            cnt_clr = 1'b1;
            if (stage_q == SW'(N_STAGE - 1)) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              stage_d = stage_q + 1'b1;
              retry_d = '0;
              state_d = S_PWR;
            end
          end
        end
        S_DONE:  done_d = 1'b1;
        S_FAULT: fault_d = 1'b1;
        default: begin
          state_d = S_PWR;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_PWR;
      cnt_q    <= '0;
      stage_q  <= '0;
      retry_q  <= '0;
      pwrdwn_q <= '1;
      rst_q    <= '1;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      retry_q  <= retry_d;
      pwrdwn_q <= pwrdwn_d;
      rst_q    <= rst_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.pwrdwn = pwrdwn_q;
  assign bus.rst    = rst_q;
  assign bus.done   = done_q;
  assign bus.fault  = fault_q;
  assign bus.stage  = stage_q;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Multi-stage power-up/reset sequencer that replaces the single free-running power-on counter for boards with several dependent domains (ADC/DAC PLLs, clock distribution, transceivers). It holds every domain in power-down and reset after configuration, then releases them one by one in index order. Each stage waits for that domain's `ready` (PLL lock) before the next stage begins. It retries stages that fail to lock, re-sequences any stage that loses lock, and reports a fault when retries are exhausted.

## Interface
- `N_STAGE`, 4: number of sequenced domains; stage 0 is released first.
- `PWR_CYCLES`, 1000000: cycles `pwrdwn[k]` stays asserted after stage `k` starts.
- `RST_CYCLES`, 20000: cycles `rst[k]` stays asserted after `pwrdwn[k]` releases.
- `TIMEOUT_CYCLES`, 4000000: maximum wait for `ready[k]` after `rst[k]` releases.
- `MAX_RETRY`, 3: timeouts allowed per stage before a fault.
- `CNT_W`, 32: width of the shared delay counter; it must hold the largest of the three cycle parameters.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset; the counter is cleared asynchronously and the sequence restarts from stage 0.
- `ready`  in  N_STAGE  per-domain lock/ready; asynchronous, so it is synchronized internally.
- `restart_req`  in  1  single-cycle pulse that restarts the whole sequence.
- `pwrdwn`  out  N_STAGE  active-high power-down, one bit per domain.
- `rst`  out  N_STAGE  active-high reset, one bit per domain.
- `done`  out  1  all stages released and locked.
- `fault`  out  1  retries exhausted on `stage`.
- `stage`  out  clog2(N_STAGE)  index of the stage currently being sequenced or faulted.

## Operation
- Reset values: `pwrdwn` all 1, `rst` all 1, `done` 0, `fault` 0, `stage` 0, retry count 0, state S_PWR.
- All outputs are registered.
- Sync: each `ready` bit passes through 2 flops. Every reference to `ready` below means the synchronized `rdy_s`.
- States and transitions:
  - S_PWR: count `PWR_CYCLES`, then clear `pwrdwn[stage]` and go to S_RST.
  - S_RST: count `RST_CYCLES`, then clear `rst[stage]` and go to S_WAIT.
  - S_WAIT, when `rdy_s[stage]` = 1:
    - If `stage` = N_STAGE-1: go to S_DONE.
    - Otherwise: `stage`+1, clear the retry count, go to S_PWR.
  - S_WAIT, when the counter reaches `TIMEOUT_CYCLES`:
    - If retry < MAX_RETRY: retry+1, reassert `pwrdwn[stage]` and `rst[stage]`, go to S_PWR.
    - Otherwise: go to S_FAULT.
  - S_DONE: `done` = 1.
  - S_FAULT: `fault` = 1. `pwrdwn` and `rst` are 1 for every stage ≥ `stage`; earlier stages keep running. The block leaves S_FAULT only on `restart_req` or `rst_n`.
- Lock loss:
  - Trigger: in S_RST, S_WAIT or S_DONE, any `rdy_s[j]` = 0 with j < `stage`. In S_DONE the trigger is any j ≤ N_STAGE-1.
  - Response: take the lowest such j; reassert `pwrdwn` and `rst` for all stages ≥ j; set `stage` = j; clear retry; clear `done`; go to S_PWR.
- `restart_req` has the highest priority in every state. It reasserts all outputs and returns to the reset values.
- Priority when events coincide in one cycle: `restart_req` > lock loss > timeout > `rdy_s[stage]` rising.
- `ready` bits for stages > `stage` are ignored.

## Timing
- The counter is cleared on every state entry and advances by 1 per cycle.
- The exit condition is count = P-1, where P is the state's cycle parameter, so a state lasts exactly P cycles.
- If S_PWR is entered at edge t: `pwrdwn[k]` falls at t+PWR_CYCLES, and `rst[k]` falls at t+PWR_CYCLES+RST_CYCLES.
- Lock detection latency: 2 sync cycles plus 1 cycle from `ready` to the state change or output change.
- The `done` rise occurs 3 cycles after the last `ready` rises.
- Lock-loss response: outputs reassert 3 cycles after the `ready` fall.
- `restart_req` response: outputs reassert on the edge after the pulse is sampled (1 cycle).
- The counter saturates and never wraps.

## Structure
- Package `reset_seq_pkg`:
  - state enum (S_PWR, S_RST, S_WAIT, S_DONE, S_FAULT);
  - `STAGE_W` = clog2(N_STAGE);
  - `RETRY_W` = clog2(MAX_RETRY+1).
- Sub-module `bit_sync2`: two-flop synchronizer with async active-low clear. It is instantiated once per `ready` bit and reused elsewhere in the design.
- Top level: one FSM, one shared counter, retry counter, and the `pwrdwn`/`rst` vector registers.

## Test plan
All scenarios use N_STAGE=3, PWR=8, RST=4, TIMEOUT=16, MAX_RETRY=2.
- Nominal: release `rst_n`; raise each `ready` 5 cycles after its `rst` falls.
  - Required: `pwrdwn[0]` falls at cycle 8 and `rst[0]` at cycle 12; stages 1 and 2 follow in order; `done` = 1 3 cycles after `ready[2]` rises.
- Retry: hold `ready[1]` = 0 for the first timeout, then raise it.
  - Required: `pwrdwn[1]`/`rst[1]` reassert 16 cycles after `rst[1]` fell; the stage re-runs once; `done` = 1; `fault` = 0.
- Fault: hold `ready[2]` = 0.
  - Required: after 3 timeouts, `fault` = 1, `stage` = 2, `pwrdwn`/`rst` = 3'b100, `done` = 0. A subsequent `restart_req` must return all outputs to the reset values.
- Lock loss: after `done`, drop `ready[1]` for 1 cycle.
  - Required: `done` = 0, `pwrdwn`/`rst` = 3'b110, `stage` = 1; the sequence then completes again.
- Coincident events: `restart_req` in the same cycle as a stage-0 timeout.
  - Required: restart wins, the retry count is 0, and `stage` = 0.
- Async reset mid-sequence: pulse `rst_n` low in S_WAIT of stage 1.
  - Required: outputs reach their reset values immediately, with no clock edge.
